// File: rtl/RS5_pkg.sv
// rtl/RS5_pkg.sv - bank state type and address bit-reversal helper for the FFT ping-pong buffer
package RS5_pkg;

    typedef enum logic [2:0] {
        EMPTY,
        FILLING,
        READY,
        ACTIVE,
        RESULT
    } fft_bank_state_t;

    // Reverse the low 'width' bits of v; bits at or above 'width' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = v[width - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_store.sv
// rtl/fft_bank_store.sv - one frame bank: word storage, written-mask, single-word and parallel write ports
module fft_bank_store #(
    parameter int WORDS      = 32,
    parameter int WORD_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(WORDS)-1:0]      wr_addr,
    input  logic [WORD_WIDTH-1:0]         wr_data,
    input  logic                          load_en,
    input  logic [WORDS*WORD_WIDTH-1:0]   load_data,
    input  logic                          mask_clr,
    input  logic [$clog2(WORDS)-1:0]      rd_addr,
    output logic [WORD_WIDTH-1:0]         rd_word,
    output logic [WORDS*WORD_WIDTH-1:0]   data_flat,
    output logic [WORDS-1:0]              mask
);

    logic [WORDS*WORD_WIDTH-1:0] mem;

    // Word storage: a result load replaces the whole frame, a CPU write replaces one word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (load_en) begin
            mem <= load_data;
        end else if (wr_en) begin
            mem[int'(wr_addr) * WORD_WIDTH +: WORD_WIDTH] <= wr_data;
        end
    end

    // Written-mask: one bit per word written since the bank was last released.
    always_ff @(posedge clk) begin
        if (rst || mask_clr) begin
            mask <= '0;
        end else if (wr_en) begin
            mask[wr_addr] <= 1'b1;
        end
    end

    assign rd_word   = mem[int'(rd_addr) * WORD_WIDTH +: WORD_WIDTH];
    assign data_flat = mem;

endmodule

// File: rtl/fft_pingpong_buffer.sv
// rtl/fft_pingpong_buffer.sv - two-bank CPU/FFT frame buffer; FFT_BITREV_EN stores CPU writes at bit-reversed addresses
module fft_pingpong_buffer
    import RS5_pkg::*;
#(
    parameter int WORDS      = 32,
    parameter int WORD_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic [$clog2(WORDS)-1:0]      addr_i,
    input  logic [31:0]                   data_i,
    output logic [31:0]                   rdata_o,
    input  logic                          release_i,
    output logic                          overflow_o,
    output logic [$clog2(WORDS):0]        fill_count_o,
    output logic                          frame_valid_o,
    input  logic                          frame_ready_i,
    output logic [WORDS*WORD_WIDTH-1:0]   frame_o,
    input  logic                          result_we_i,
    input  logic [WORDS*WORD_WIDTH-1:0]   result_i,
    input  logic                          result_done_i,
    output logic                          result_valid_o
);

    localparam int AW = $clog2(WORDS);
    localparam int CW = AW + 1;

    fft_bank_state_t state_q [2];
    fft_bank_state_t state_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            acc_ptr_q, acc_ptr_d;
    logic            res_ptr_q, res_ptr_d;

    logic [1:0]                  bank_wr_en;
    logic [1:0]                  bank_load_en;
    logic [1:0]                  bank_mask_clr;
    logic [WORD_WIDTH-1:0]       bank_rd_word [2];
    logic [WORDS*WORD_WIDTH-1:0] bank_flat    [2];
    logic [WORDS-1:0]            bank_mask    [2];

    logic          cpu_wr, cpu_rd, wr_open, overflow_set, rd_sel;
    logic [AW-1:0] wr_idx;
    logic [WORDS-1:0] wr_onehot;
    logic [CW-1:0] popcnt;

`ifdef FFT_BITREV_EN
    logic [31:0] addr_rev;
    logic        unused_bits;
    assign addr_rev    = bitrev({{(32-AW){1'b0}}, addr_i}, AW);
    assign wr_idx      = addr_rev[AW-1:0];
    assign unused_bits = ^{data_i, addr_rev};
`else
    logic        unused_bits;
    assign wr_idx      = addr_i;
    assign unused_bits = ^data_i;
`endif

    assign cpu_wr    = en_i & we_i;
    assign cpu_rd    = en_i & ~we_i;
    assign wr_open   = (state_q[wr_ptr_q] == EMPTY) || (state_q[wr_ptr_q] == FILLING);
    assign wr_onehot = WORDS'(1) << wr_idx;
    assign rd_sel    = (state_q[res_ptr_q] == RESULT) ? res_ptr_q : wr_ptr_q;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_bank_store #(
            .WORDS      (WORDS),
            .WORD_WIDTH (WORD_WIDTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (bank_wr_en[g]),
            .wr_addr   (wr_idx),
            .wr_data   (data_i[WORD_WIDTH-1:0]),
            .load_en   (bank_load_en[g]),
            .load_data (result_i),
            .mask_clr  (bank_mask_clr[g]),
            .rd_addr   (addr_i),
            .rd_word   (bank_rd_word[g]),
            .data_flat (bank_flat[g]),
            .mask      (bank_mask[g])
        );
    end

    // Bank states and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_ptr_q   <= 1'b0;
            acc_ptr_q  <= 1'b0;
            res_ptr_q  <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_ptr_q   <= wr_ptr_d;
            acc_ptr_q  <= acc_ptr_d;
            res_ptr_q  <= res_ptr_d;
        end
    end

    // Next-state: each event only acts on a bank in one specific state, so the four never collide on one bank.
    always_comb begin
        state_d[0]    = state_q[0];
        state_d[1]    = state_q[1];
        wr_ptr_d      = wr_ptr_q;
        acc_ptr_d     = acc_ptr_q;
        res_ptr_d     = res_ptr_q;
        bank_wr_en    = '0;
        bank_load_en  = '0;
        bank_mask_clr = '0;
        overflow_set  = 1'b0;

        if (cpu_wr) begin
            if (wr_open) begin
                bank_wr_en[wr_ptr_q] = 1'b1;
                if ((bank_mask[wr_ptr_q] | wr_onehot) == {WORDS{1'b1}}) begin
                    state_d[wr_ptr_q] = READY;
                    wr_ptr_d          = ~wr_ptr_q;
                end else begin
                    state_d[wr_ptr_q] = FILLING;
                end
            end else begin
                overflow_set = 1'b1;
            end
        end

        if ((state_q[acc_ptr_q] == READY) && frame_ready_i) begin
            state_d[acc_ptr_q] = ACTIVE;
        end

        if (state_q[acc_ptr_q] == ACTIVE) begin
            bank_load_en[acc_ptr_q] = result_we_i;
            if (result_done_i) begin
                state_d[acc_ptr_q] = RESULT;
                acc_ptr_d          = ~acc_ptr_q;
            end
        end

        if ((state_q[res_ptr_q] == RESULT) && release_i) begin
            state_d[res_ptr_q]       = EMPTY;
            bank_mask_clr[res_ptr_q] = 1'b1;
            res_ptr_d                = ~res_ptr_q;
        end
    end

    // Registered CPU read data and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (cpu_rd) begin
                rdata_o <= 32'(bank_rd_word[rd_sel]);
            end
            if (overflow_set) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Count written words in the bank the CPU is currently filling.
    always_comb begin
        popcnt = '0;
        for (int i = 0; i < WORDS; i++) begin
            popcnt = popcnt + CW'(bank_mask[wr_ptr_q][i]);
        end
    end

    assign fill_count_o   = wr_open ? popcnt : '0;
    assign frame_valid_o  = (state_q[acc_ptr_q] == READY);
    assign frame_o        = bank_flat[acc_ptr_q];
    assign result_valid_o = (state_q[res_ptr_q] == RESULT);

endmodule
